// File: rtl/demux8_1to4_reg_pkg.sv
// Shared definitions for the registered 1-to-4 byte distributor: widths, lane
// indices, FSM encoding and the round-robin pointer helper.
package demux8_1to4_reg_pkg;

    localparam int WIDTH = 8;
    localparam int LANES = 4;

    localparam logic [1:0] LANE_A = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;
    localparam logic [1:0] LANE_D = 2'd3;

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    // 2-bit wrap-around, 3 rolls over to 0 without width growth
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/demux8_1to4_reg_lane_reg8.sv
// One lane storage register with synchronous active-low reset and load enable.
module lane_reg8
    import demux8_1to4_reg_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // lane data register; holds its value unless loaded or reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/demux8_1to4_reg.sv
// Registered 1-to-4 byte distributor: fills lanes A..D by address or round-robin
// and offers the completed 4-byte frame under valid/ready.
module demux8_1to4_reg
    import demux8_1to4_reg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic             mode,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       lane_valid,
    output logic             frame_valid,
    input  logic             out_ready,
    output logic             overwrite,
    output logic [1:0]       ptr
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       lane_valid_r;
    logic [3:0]       lane_valid_nxt_s;
    logic [1:0]       ptr_r;
    logic [1:0]       ptr_nxt_s;
    logic             overwrite_r;
    logic             overwrite_nxt_s;
    logic             accept_s;
    logic             release_s;
    logic [1:0]       target_s;
    logic [3:0]       target_oh_s;
    logic [WIDTH-1:0] lane_q_s [LANES];

    assign in_ready    = (state_r == S_FILL);
    assign frame_valid = (state_r == S_FULL);
    assign lane_valid  = lane_valid_r;
    assign ptr         = ptr_r;
    assign overwrite   = overwrite_r;

    assign accept_s    = in_valid && (state_r == S_FILL);
    assign release_s   = (state_r == S_FULL) && out_ready;
    assign target_s    = mode ? ptr_r : sel;
    assign target_oh_s = 4'b0001 << target_s;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_reg8 #(.W(WIDTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept_s && (target_s == 2'(i))),
            .d     (in),
            .q     (lane_q_s[i])
        );
    end

    assign a = lane_q_s[LANE_A];
    assign b = lane_q_s[LANE_B];
    assign c = lane_q_s[LANE_C];
    assign d = lane_q_s[LANE_D];

    // next-state, valid mask, pointer and overwrite decode
    always_comb begin
        state_nxt_s      = state_r;
        lane_valid_nxt_s = lane_valid_r;
        ptr_nxt_s        = ptr_r;
        overwrite_nxt_s  = 1'b0;
        case (state_r)
            S_FILL: begin
                if (accept_s) begin
                    lane_valid_nxt_s = lane_valid_r | target_oh_s;
                    overwrite_nxt_s  = |(lane_valid_r & target_oh_s);
                    if (mode) begin
                        ptr_nxt_s = ptr_inc(ptr_r);
                    end else begin
                        ptr_nxt_s = ptr_r;
                    end
                    if ((lane_valid_r | target_oh_s) == 4'hF) begin
                        state_nxt_s = S_FULL;
                    end else begin
                        state_nxt_s = S_FILL;
                    end
                end else begin
                    state_nxt_s = S_FILL;
                end
            end
            S_FULL: begin
                if (release_s) begin
                    lane_valid_nxt_s = 4'h0;
                    ptr_nxt_s        = 2'd0;
                    state_nxt_s      = S_FILL;
                end else begin
                    state_nxt_s = S_FULL;
                end
            end
            default: begin
                state_nxt_s      = S_FILL;
                lane_valid_nxt_s = 4'h0;
                ptr_nxt_s        = 2'd0;
            end
        endcase
    end

    // control state registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_FILL;
            lane_valid_r <= 4'h0;
            ptr_r        <= 2'd0;
            overwrite_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            lane_valid_r <= lane_valid_nxt_s;
            ptr_r        <= ptr_nxt_s;
            overwrite_r  <= overwrite_nxt_s;
        end
    end

endmodule

// File: tb/tb_demux8_1to4_reg.sv
// Self-checking bench for demux8_1to4_reg: directed scenarios then random traffic,
// compared every cycle against a behavioural frame-assembly model.
module tb_demux8_1to4_reg;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic       mode;
    logic [7:0] a, b, c, d;
    logic [3:0] lane_valid;
    logic       frame_valid;
    logic       out_ready;
    logic       overwrite;
    logic [1:0] ptr;

    int vectors;
    int miscompares;

    // reference model state
    int m_lane [4];
    int m_valid;
    int m_full;
    int m_ptr;
    int m_ovw;

    demux8_1to4_reg dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .a(a), .b(b), .c(c), .d(d), .lane_valid(lane_valid),
        .frame_valid(frame_valid), .out_ready(out_ready), .overwrite(overwrite), .ptr(ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_lane[i] = 0;
        m_valid = 0;
        m_full  = 0;
        m_ptr   = 0;
        m_ovw   = 0;
    endtask

    // one clock: drive inputs, check in_ready, advance model, check all outputs
    task automatic cyc(input bit rst, input bit iv, input int din, input int s,
                       input bit md, input bit ordy);
        int t;
        bit acc;
        bit rel;
        rst_n = rst; in_valid = iv; in = din[7:0]; sel = s[1:0]; mode = md; out_ready = ordy;
        #1;
        check("in_ready", int'(in_ready), m_full ? 0 : 1);
        @(posedge clk);
        vectors++;
        if (!rst) begin
            model_reset();
        end else begin
            acc = iv && (m_full == 0);
            rel = (m_full == 1) && ordy;
            m_ovw = 0;
            if (acc) begin
                t = md ? m_ptr : s;
                m_ovw = (m_valid >> t) & 1;
                m_lane[t] = din & 255;
                m_valid = m_valid | (1 << t);
                if (md) m_ptr = (m_ptr + 1) % 4;
                if (m_valid == 15) m_full = 1;
            end
            if (rel) begin
                m_valid = 0;
                m_ptr = 0;
                m_full = 0;
            end
        end
        #1;
        check("a", int'(a), m_lane[0]);
        check("b", int'(b), m_lane[1]);
        check("c", int'(c), m_lane[2]);
        check("d", int'(d), m_lane[3]);
        check("lane_valid", int'(lane_valid), m_valid);
        check("frame_valid", int'(frame_valid), m_full);
        check("overwrite", int'(overwrite), m_ovw);
        check("ptr", int'(ptr), m_ptr);
    endtask

    initial begin
        int seq [4];
        vectors = 0;
        miscompares = 0;
        model_reset();
        rst_n = 1'b0; in = 8'h00; in_valid = 1'b0; sel = 2'd0; mode = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

        // 1: round-robin fill, then release
        seq = '{32'hAA, 32'h55, 32'hF0, 32'h0F};
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, seq[i], 0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 1'b1, 1'b1);
        check("t1_ptr_after_release", int'(ptr), 0);
        check("t1_lane_a", int'(a), 32'hAA);

        // 2: addressed fill in reverse order
        seq = '{32'h0F, 32'hF0, 32'h55, 32'hAA};
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, seq[i], 3 - i, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);

        // 3: repeated lane write, frame completes on the 5th write
        cyc(1'b1, 1'b1, 32'h11, 1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h22, 1, 1'b0, 1'b0);
        check("t3_overwrite", int'(overwrite), 1);
        cyc(1'b1, 1'b1, 32'h33, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h44, 2, 1'b0, 1'b0);
        check("t3_not_full", int'(frame_valid), 0);
        cyc(1'b1, 1'b1, 32'h66, 3, 1'b0, 1'b0);
        check("t3_full", int'(frame_valid), 1);
        check("t3_lane_b", int'(b), 32'h22);

        // 4: backpressure while full, then release and next byte into A
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 32'h90 + i, i % 4, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 32'h99, 0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 32'h77, 0, 1'b1, 1'b0);
        check("t4_next_in_a", int'(a), 32'h77);

        // 5: reset mid-frame
        cyc(1'b1, 1'b1, 32'h12, 0, 1'b1, 1'b0);
        check("t5_ptr2", int'(ptr), 2);
        cyc(1'b0, 1'b1, 32'h34, 0, 1'b1, 1'b0);
        check("t5_lv_cleared", int'(lane_valid), 0);
        cyc(1'b1, 1'b1, 32'h56, 0, 1'b1, 1'b0);
        check("t5_lands_a", int'(a), 32'h56);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

        // 6: mode switch mid-frame keeps the pointer
        cyc(1'b1, 1'b1, 32'hA1, 0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 32'hD4, 3, 1'b0, 1'b0);
        check("t6_ptr_held", int'(ptr), 1);
        cyc(1'b1, 1'b1, 32'hB2, 0, 1'b1, 1'b0);
        check("t6_lane_b", int'(b), 32'hB2);
        check("t6_lane_d", int'(d), 32'hD4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0), 1'($urandom), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
